// File: rtl/peres_pkg.sv
// peres_pkg: Peres gate primitives and parameter checks for the reversible adder pipeline
package peres_pkg;

  function automatic logic [2:0] peres(input logic a, input logic b, input logic c);
    return {a, a ^ b, (a & b) ^ c};
  endfunction

  function automatic logic [1:0] peres_fa(input logic a, input logic b, input logic c);
    logic [1:0] g1, g2;
    g1 = 2'(peres(a, b, 1'b0));
    g2 = 2'(peres(g1[1], c, g1[0]));
    return g2;
  endfunction

  function automatic bit seg_ok(input int width, input int seg);
    return seg > 0 && width >= seg && width % seg == 0;
  endfunction

endpackage

// File: rtl/peres_seg_add.sv
// peres_seg_add: SEG-bit combinational ripple of two-Peres-gate full adders
module peres_seg_add
  import peres_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SEG; i++) {sum[i], c[i+1]} = peres_fa(a[i], b[i], c[i]);
  end
  assign cout = c[SEG];
endmodule

// File: rtl/peres_adder_pipe.sv
// peres_adder_pipe: pipelined Peres-gate adder/subtractor, SEG bits per stage,
// carry registered between stages, independent valid/ready stall per stage
module peres_adder_pipe
  import peres_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NSTG = WIDTH / SEG;

  if (!seg_ok(WIDTH, SEG)) begin : g_bad
    $error("peres_adder_pipe: WIDTH must be a nonzero multiple of SEG");
  end

  logic [NSTG-1:0] vld_d, vld_q, vsrc, rdy, ld;

  always_comb begin : p_rdy
    logic r;
    r = out_ready;
    for (int i = NSTG - 1; i >= 0; i--) begin
      r = !vld_q[i] || r;
      rdy[i] = r;
    end
  end

  always_comb begin
    vsrc = NSTG'({vld_q, in_valid});
    for (int i = 0; i < NSTG; i++) begin
      ld[i] = rdy[i] && vsrc[i];
      vld_d[i] = rdy[i] ? vsrc[i] : vld_q[i];
    end
  end

  always_ff @(posedge clk) vld_q <= rst ? '0 : vld_d;

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[NSTG-1];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;
    logic [WIDTH-1:LO] a_src, b_src;
    logic [HI-1:0]     sum_d, sum_q;
    logic [SEG-1:0]    seg_sum;
    logic              c_src, cy_d, cy_q;

    peres_seg_add #(.SEG(SEG)) u_add (
      .a   (a_src[HI-1:LO]),
      .b   (b_src[HI-1:LO]),
      .cin (c_src),
      .sum (seg_sum),
      .cout(cy_d)
    );

    // Stage 0 applies subtract-mode inversion; later stages consume the previous stage's leftovers
    if (k == 0) begin : g_src
      always_comb begin
        a_src = in_a;
        b_src = in_b ^ {WIDTH{in_sub}};
        c_src = in_cin ^ in_sub;
        sum_d = seg_sum;
      end
    end else begin : g_src
      always_comb begin
        a_src = g_stg[k-1].g_ops.a_q;
        b_src = g_stg[k-1].g_ops.b_q;
        c_src = g_stg[k-1].cy_q;
        sum_d = {seg_sum, g_stg[k-1].sum_q};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else if (ld[k]) begin
        sum_q <= sum_d;
        cy_q  <= cy_d;
      end
    end

    if (k < NSTG - 1) begin : g_ops
      logic [WIDTH-1:HI] a_d, b_d, a_q, b_q;
      always_comb begin
        a_d = a_src[WIDTH-1:HI];
        b_d = b_src[WIDTH-1:HI];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[k]) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic cmsb_d, cmsb_q;
      // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the MSB's sum
      always_comb cmsb_d = seg_sum[SEG-1] ^ a_src[WIDTH-1] ^ b_src[WIDTH-1];
      always_ff @(posedge clk) begin
        if (rst) cmsb_q <= 1'b0;
        else if (ld[k]) cmsb_q <= cmsb_d;
      end
      assign out_sum  = sum_q;
      assign out_cout = cy_q;
      assign out_ovf  = cy_q ^ cmsb_q;
    end
  end

endmodule

// File: tb/tb_peres_adder_pipe.sv
// tb_peres_adder_pipe: scoreboard bench for the pipelined Peres adder (16/4 and 8/8 builds)
module tb_peres_adder_pipe;
  localparam int W  = 16;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  logic       v8 = 1'b0, c8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       r8, ov8, co8, of8;
  logic [7:0] sum8;

  peres_adder_pipe #(.WIDTH(16), .SEG(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  peres_adder_pipe #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_cin(c8), .in_sub(s8), .out_valid(ov8), .out_ready(or8),
    .out_sum(sum8), .out_cout(co8), .out_ovf(of8)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] held_v, got_v, e;
  bit held = 1'b0;
  assign got_v = {out_cout, out_ovf, out_sum};

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] f;
    bb = sub ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {16'd0, sub ? ~cin : cin};
    return {f[16], (a[15] == bb[15]) && (f[15] != a[15]), f[15:0]};
  endfunction

  // scoreboard: push on input transfer, pop on output transfer, hold-stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got_v !== held_v) begin
          n_err++;
          $display("FAIL stall_stable got v=%0b %h want v=1 %h", out_valid, got_v, held_v);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got %h want no output", got_v);
        end else begin
          e = exp_q.pop_front();
          if (got_v !== e) begin
            n_err++;
            $display("FAIL sb_result got %h want %h", got_v, e);
          end
        end
      end
      held   = out_valid && !out_ready;
      held_v = got_v;
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (out_valid || exp_q.size() != 0); i++) tick();
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [17:0] got, output int lat);
    in_a = a; in_b = b; in_cin = c; in_sub = s;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    got = got_v;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%0b sum=%h c=%0b o=%0b want all 0", out_valid, out_sum, out_cout, out_ovf);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    n_cmp++;
    if ({ov8, sum8, co8, of8} !== '0 || r8 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_w8 got v=%0b sum=%h rdy=%0b want v=0 sum=00 rdy=1", ov8, sum8, r8);
    end
  endtask

  task automatic test_latency();
    logic [17:0] got;
    int lat;
    run_one(16'h1234, 16'h0F0F, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (lat != NS) begin
      n_err++;
      $display("FAIL latency got %0d want %0d", lat, NS);
    end
    n_cmp++;
    if (got !== {2'b00, 16'h2143}) begin
      n_err++;
      $display("FAIL add_1234_0f0f got %h want %h", got, {2'b00, 16'h2143});
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
    logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] te [5] = '{{2'b01, 16'h8000}, {2'b10, 16'h0000}, {2'b00, 16'hFFFE},
                            {2'b11, 16'h7FFF}, {2'b10, 16'h000C}};
    logic [17:0] got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_one(ta[i], tb[i], tc[i], ts[i], got, lat);
      n_cmp++;
      if (got !== te[i] || lat != NS) begin
        n_err++;
        $display("FAIL directed_%0d got %h lat=%0d want %h lat=%0d", i, got, lat, te[i], NS);
      end
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    bit xfer;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
      out_ready = 1'($urandom);
      if (!in_valid) begin
        rand_op();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      xfer = in_valid && in_ready;
      tick();
      if (xfer) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    drain();
    n_cmp++;
    if (sent != 100 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain got sent=%0d pending=%0d want sent=100 pending=0", sent, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bit xfer;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_op();
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready cycle %0d got %0b want 1", i, in_ready);
      end
      if (i >= NS) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_out_valid cycle %0d got %0b want 1", i, out_valid);
        end
      end
      tick();
    end
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_op();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== (acc < NS)) begin
        n_err++;
        $display("FAIL fill_in_ready held=%0d got %0b want %0b", acc, in_ready, acc < NS);
      end
      xfer = in_ready;
      tick();
      if (xfer) begin
        acc++;
        rand_op();
      end
    end
    n_cmp++;
    if (acc != NS) begin
      n_err++;
      $display("FAIL fill_count got %0d want %0d", acc, NS);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [17:0] got;
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1111 * 16'(i + 1); in_b = 16'h0101; in_cin = 1'b1; in_sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_pre got v=%0b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_reset got v=%0b sum=%h c=%0b o=%0b rdy=%0b want 0 0000 0 0 rdy=1",
               out_valid, out_sum, out_cout, out_ovf, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midflight_stale cycle %0d got v=%0b want 0", i, out_valid);
      end
    end
    run_one(16'h00FF, 16'h0001, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {2'b00, 16'h0100} || lat != NS) begin
      n_err++;
      $display("FAIL post_reset_op got %h lat=%0d want %h lat=%0d", got, lat, {2'b00, 16'h0100}, NS);
    end
  endtask

  task automatic test_width8();
    logic [7:0]  ta [4] = '{8'h12, 8'h7F, 8'hFF, 8'h05};
    logic [7:0]  tb [4] = '{8'h0F, 8'h01, 8'h01, 8'h07};
    logic        ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0]  te [4] = '{{2'b00, 8'h21}, {2'b01, 8'h80}, {2'b10, 8'h00}, {2'b00, 8'hFE}};
    or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = 1'b0; s8 = ts[i]; v8 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (r8 !== 1'b1 || ov8 !== 1'b0) begin
        n_err++;
        $display("FAIL w8_pre_%0d got rdy=%0b v=%0b want rdy=1 v=0", i, r8, ov8);
      end
      tick();
      v8 = 1'b0;
      n_cmp++;
      if ({ov8, co8, of8, sum8} !== {1'b1, te[i]}) begin
        n_err++;
        $display("FAIL w8_op_%0d got %h want %h", i, {ov8, co8, of8, sum8}, {1'b1, te[i]});
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_stream();
    test_back_to_back();
    test_reset_midflight();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/peres_adder_pipe.md
# peres_adder_pipe

Parametrised, pipelined reversible-logic adder/subtractor built entirely from Peres gates, with two Peres gates per bit forming a full adder. A WIDTH-bit operation is split into SEG-bit segments, one pipeline stage each, with carry registered between stages. Valid/ready handshakes sit on both sides, so the block drops into the streaming datapath next to the TCAM match logic. Each stage stalls independently under backpressure.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; number of stages NSTG = WIDTH/SEG (derived, not overridable).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; acts as borrow-in when in_sub=1.
- in_sub  input  1  0 = A+B+cin, 1 = A−B−cin.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result bits.
- out_cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.

## Operation
- Peres gate: P=A, Q=A^B, R=(A&B)^C.
- Full adder per bit:
  - gate 1 = Peres(a, b, 0), giving Q1=a^b and R1=a&b.
  - gate 2 = Peres(Q1, c, R1), giving sum = Q2 and cout = R2.
- Subtract mode: b replaced by ~in_b; effective carry-in = in_sub ? ~in_cin : in_cin.
- Stage k (0..NSTG−1) resolves bits [k*SEG +: SEG] by rippling SEG full adders from the carry held in stage k−1.
  - Stage 0 uses the effective carry-in.
- Stage register k holds:
  - valid bit;
  - sum bits [0 .. (k+1)*SEG−1];
  - unprocessed operand bits of A and B' (B after subtract-mode inversion);
  - carry out of its segment;
  - carry into the MSB (last stage only).
- out_sum, out_cout and out_ovf come from the last stage register.
- out_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, in both modes.
- Handshake:
  - ready_k = !valid_k || ready_{k+1}, with ready_NSTG = out_ready; in_ready = ready_0.
  - A stage loads when its own ready is high. It loads valid from the previous stage, or from in_valid for stage 0.
  - A transfer occurs on any cycle where valid and ready are both high on an interface.
- Data registers load only on transfer, so bubbles leave data registers unchanged.
- in_a, in_b, in_cin and in_sub are sampled only on an input transfer; upstream may change them freely otherwise.
- Reset:
  - all valid bits, data registers, out_sum, out_cout and out_ovf go to 0;
  - in_ready reads 1 on the first cycle after reset.
- Reset mid-operation discards all in-flight results; no partial output appears.
- Simultaneous events: a full pipe with out_ready=1 still accepts a new input in the same cycle (full throughput, no bubble).

## Timing
- Latency: operation accepted at edge t gives out_valid=1 after edge t+NSTG−1, i.e. NSTG cycles of registers.
- Throughput: one operation per cycle while out_ready=1.
- in_ready is combinational from out_ready, with the path through NSTG valid bits. Combinational depth per stage is SEG bits of ripple: 2·SEG Peres gates.
- Backpressure:
  - out_ready=0 with the pipe full drops in_ready in the same cycle.
  - Up to NSTG results are held, none lost or duplicated, and order is preserved.
- out_sum, out_cout and out_ovf stay stable while out_valid=1 and out_ready=0.

## Structure
- Shared package peres_pkg:
  - function peres(a,b,c) returning {P,Q,R};
  - function peres_fa(a,b,c) returning {sum,cout};
  - a compile-time check that WIDTH % SEG == 0.
- One natural sub-module: peres_seg_add, a SEG-bit combinational ripple of peres_fa. It is instantiated once per stage in a generate loop.
- Top level holds only the stage registers and the ready chain.

## Test plan
- Defaults, add 0x1234+0x0F0F with cin=0 → out_sum=0x2143, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- Add 0x7FFF+0x0001 → out_sum=0x8000, ovf=1, cout=0; add 0xFFFF+0x0001 → out_sum=0x0000, cout=1, ovf=0.
- Subtract 0x0005−0x0007 with in_cin=0 → out_sum=0xFFFE, cout=0; subtract 0x8000−0x0001 → out_sum=0x7FFF, ovf=1.
- Stream 100 random ops with random out_ready (≈50% duty) → results match a reference model in order, no drops or duplicates, outputs stable while stalled.
- Back-to-back input with out_ready=1 → in_ready constantly 1 and one result per cycle. Fill with out_ready=0 → in_ready=0 once 4 ops are held.
- Assert rst with 3 ops in flight → next cycle out_valid=0 and outputs zero. The post-reset op returns a correct result with no stale data. Also repeat the directed adds with WIDTH=8, SEG=8 (single stage, latency 1).
